// File: rtl/rsa_pkg.sv
// Shared types for the modular exponentiation engine: FSM state encoding and
// the fixed latency of one serial modular multiply.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SCAN  = 3'd2,
    SQR   = 3'd3,
    MUL   = 3'd4,
    NEXT  = 3'd5,
    DONE  = 3'd6
  } state_t;

  // One load cycle plus one iteration per multiplier bit.
  function automatic int mul_lat(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Interleaved MSB-first modular multiplier: p = a*b mod n in WIDTH+1 cycles.
// Operands must satisfy a,b < n; done is a one-cycle pulse with p valid alongside it.
module mod_mul_serial
  import rsa_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(mul_lat(WIDTH) - 2);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH+1:0] b_q, b_d;
  logic [WIDTH+1:0] n_q, n_d;
  logic [WIDTH+1:0] r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [WIDTH+1:0] dbl, sum, r_step;

  // r < n is an invariant, so a single conditional subtract keeps each step reduced.
  always_comb begin
    dbl = {r_q[WIDTH:0], 1'b0};
    if (dbl >= n_q) dbl = dbl - n_q;
    sum = a_q[WIDTH-1] ? (dbl + b_q) : dbl;
    r_step = sum;
    if (sum >= n_q) r_step = sum - n_q;
  end

  assign done = run_q && (cnt_q == '0);
  assign p    = r_step[WIDTH-1:0];

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    n_d   = n_q;
    r_d   = r_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (clear) begin
      run_d = 1'b0;
    end else if (start) begin
      a_d   = a;
      b_d   = {2'b00, b};
      n_d   = {2'b00, n};
      r_d   = '0;
      cnt_d = ITER_LAST;
      run_d = 1'b1;
    end else if (run_q) begin
      r_d   = r_step;
      a_d   = {a_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == '0) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      n_q   <= n_d;
      r_q   <= r_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/mod_exp_hs.sv
// Handshaked left-to-right square-and-multiply engine: result = msg^exp mod modulus.
// Define MOD_EXP_SKIP_LZ_EN to skip leading zero exponent bits before the first square.
module mod_exp_hs
  import rsa_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] msg,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] modulus,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             busy
);

  localparam int IW = CNT_W - 1;
  localparam logic [CNT_W-1:0] IDX_TOP = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] msg_q, msg_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             started_q, started_d;

  logic             mul_start, mul_clear, mul_done;
  logic [WIDTH-1:0] mul_b, mul_p;
  logic [IW-1:0]    bit_sel;
  logic [CNT_W-1:0] idx_m1;

  assign bit_sel = idx_q[IW-1:0];
  assign idx_m1  = idx_q - CNT_W'(1);
  assign mul_b   = (state_q == MUL) ? msg_q : acc_q;

  mod_mul_serial #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .clear   (mul_clear),
    .a       (acc_q),
    .b       (mul_b),
    .n       (mod_q),
    .done    (mul_done),
    .p       (mul_p)
  );

  always_comb begin
    state_d   = state_q;
    msg_d     = msg_q;
    exp_d     = exp_q;
    mod_d     = mod_q;
    acc_d     = acc_q;
    result_d  = result_q;
    idx_d     = idx_q;
    err_d     = err_q;
    started_d = started_q;
    mul_start = 1'b0;
    mul_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          msg_d   = msg;
          exp_d   = exp;
          mod_d   = modulus;
          err_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if ((mod_q < WIDTH'(2)) || (msg_q >= mod_q)) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = DONE;
        end else begin
          acc_d = WIDTH'(1);
          idx_d = IDX_TOP;
`ifdef MOD_EXP_SKIP_LZ_EN
          state_d = exp_q[WIDTH-1] ? SQR : SCAN;
`else
          state_d = SQR;
`endif
        end
      end
`ifdef MOD_EXP_SKIP_LZ_EN
      // Entered only on a zero bit above bit 0; stop on the next one bit or at bit 0.
      SCAN: begin
        idx_d = idx_m1;
        if (exp_q[idx_m1[IW-1:0]] || (idx_m1 == '0)) state_d = SQR;
      end
`endif
      SQR, MUL: begin
        if (!started_q) begin
          mul_start = 1'b1;
          started_d = 1'b1;
        end else if (mul_done) begin
          acc_d     = mul_p;
          started_d = 1'b0;
          state_d   = ((state_q == SQR) && exp_q[bit_sel]) ? MUL : NEXT;
        end
      end
      NEXT: begin
        if (idx_q == '0) begin
          result_d = acc_q;
          state_d  = DONE;
        end else begin
          idx_d   = idx_m1;
          state_d = SQR;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q inside {CHECK, SCAN, SQR, MUL, NEXT})) begin
      state_d   = IDLE;
      started_d = 1'b0;
      mul_start = 1'b0;
      mul_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      msg_q     <= '0;
      exp_q     <= '0;
      mod_q     <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      msg_q     <= msg_d;
      exp_q     <= exp_d;
      mod_q     <= mod_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      started_q <= started_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mod_exp_hs.sv
// Scoreboard bench for mod_exp_hs at WIDTH=16: stimulus pushes expected results,
// a monitor pops and compares on every output transfer.
module tb_mod_exp_hs;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
    int           hs;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] msg = '0;
  logic [W-1:0] exp = '0;
  logic [W-1:0] modulus = '0;
  logic         abort = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         err;
  logic         busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_cyc = 0;
  exp_t sb[$];

  mod_exp_hs #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .msg       (msg),
    .exp       (exp),
    .modulus   (modulus),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] e);
    int pc;
    int lz;
    pc = $countones(e);
    lz = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (e[i]) break;
      lz++;
    end
`ifdef MOD_EXP_SKIP_LZ_EN
    return 1 + lz + (W - lz) * (W + 2) + pc * (W + 1) + 1;
`else
    lz = 0;
    return 1 + lz + W * (W + 2) + pc * (W + 1) + 1;
`endif
  endfunction

  task automatic send(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] n,
                      input logic [W-1:0] res, input logic er, input int lat, input bit push);
    exp_t t;
    int k;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    msg = m;
    exp = e;
    modulus = n;
    k = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      k++;
      if (k > 3000) begin
        chk("in_ready_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    t.res = res;
    t.err = er;
    t.lat = lat;
    t.hs  = cyc;
    if (push) sb.push_back(t);
    $display("send msg=%0d exp=%0d mod=%0d expect=%0d err=%0d push=%0d", m, e, n, res, er, push);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if ((sb.size() == 0) && in_ready) break;
      k++;
      if (k > 3000) begin
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        break;
      end
    end
  endtask

  // Monitor: compares every output transfer against the oldest expectation.
  initial begin
    logic ov_prev;
    exp_t e;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !ov_prev) rise_cyc = cyc;
      ov_prev = out_valid;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(result), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          $display("recv result=%0d err=%0d expect=%0d/%0d", result, err, e.res, e.err);
          chk("result", 32'(result), 32'(e.res));
          chk("err", 32'(err), 32'(e.err));
          if (e.lat > 0) chk("latency", 32'(rise_cyc - e.hs + 1), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int hits;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;

    send(16'd4, 16'd13, 16'd497, 16'd445, 1'b0, exp_lat(16'd13), 1'b1);
    wait_drain();
    send(16'd65, 16'd17, 16'd3233, 16'd2790, 1'b0, exp_lat(16'd17), 1'b1);
    send(16'd2790, 16'd2753, 16'd3233, 16'd65, 1'b0, exp_lat(16'd2753), 1'b1);
    send(16'd5, 16'd0, 16'd7, 16'd1, 1'b0, 0, 1'b1);
    send(16'd7, 16'd5, 16'd7, 16'd0, 1'b1, 2, 1'b1);
    send(16'd0, 16'd3, 16'd1, 16'd0, 1'b1, 2, 1'b1);
    send(16'd9, 16'd3, 16'd8, 16'd0, 1'b1, 2, 1'b1);
    send(16'd2, 16'd10, 16'd1000, 16'd24, 1'b0, 0, 1'b1);
    wait_drain();

    // Back-pressure: output must hold while out_ready is low.
    out_ready = 1'b0;
    send(16'd3, 16'd4, 16'd11, 16'd4, 1'b0, 0, 1'b1);
    k = 0;
    while (!out_valid && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("hold_valid_seen", 32'(out_valid), 32'd1);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || result !== 16'd4 || err !== 1'b0 || in_ready !== 1'b0) hits++;
    end
    chk("hold_stable_bad_cycles", 32'(hits), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_xfer_in_ready", 32'(in_ready), 32'd1);
    chk("post_xfer_out_valid", 32'(out_valid), 32'd0);

    // Abort mid-square: no output, back to IDLE next cycle.
    send(16'd4, 16'd13, 16'd497, 16'd0, 1'b0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    hits = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    chk("abort_no_output", 32'(hits), 32'd0);

    // Asynchronous reset in the middle of the first multiply step.
    send(16'd3, 16'h8001, 16'd497, 16'd0, 1'b0, 0, 1'b0);
    repeat (25) @(posedge clk);
    #2;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    send(16'd2, 16'd10, 16'd1000, 16'd24, 1'b0, exp_lat(16'd10), 1'b1);
    send(16'd65, 16'd17, 16'd3233, 16'd2790, 1'b0, 0, 1'b1);
    wait_drain();
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
